// File: rtl/instr_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_feeder
//  Description : Synthesizable instruction source for the RISC-V datapath.
//                A host loads up to DEPTH words into a small store over the
//                load port. On start the block issues them in order over a
//                valid/ready handshake, then raises done.
//
//  Ports
//    clk          system clock, rising-edge
//    reset        synchronous active-high reset
//    load_en      write load_data to entry load_addr (IDLE/DONE only)
//    load_addr    entry index for the write
//    load_data    instruction word to store
//    clear        invalidate every entry (IDLE/DONE only)
//    start        begin issuing from entry 0
//    instr_ready  datapath accepts the current word this cycle
//    instruction  current word, 0 when instr_valid is low
//    instr_valid  instruction is meaningful
//    fetch_pc     byte address of the current word (idx*4), 0 outside RUN
//    num_inst     program length latched at start
//    issued_cnt   handshakes completed in the current run
//    busy         high while issuing
//    done         high once the program has been fully issued
//    load_err     one-cycle pulse after load_en/clear is attempted in RUN
//
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_feeder #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,   // 2**ADDR_W must equal DEPTH
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [XLEN-1:0]   load_data,
    input  logic              clear,
    input  logic              start,
    input  logic              instr_ready,
    output logic [XLEN-1:0]   instruction,
    output logic              instr_valid,
    output logic [31:0]       fetch_pc,
    output logic [ADDR_W:0]   num_inst,
    output logic [ADDR_W:0]   issued_cnt,
    output logic              busy,
    output logic              done,
    output logic              load_err
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [ADDR_W:0]   c_CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [XLEN-1:0]   r_mem [DEPTH];
    logic [DEPTH-1:0]  r_vld;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W:0]   r_num_inst;
    logic [ADDR_W:0]   r_issued;
    logic              r_load_err;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [1:0]        w_state_nxt;
    logic              w_in_run;
    logic              w_do_clear;
    logic              w_do_load;
    logic              w_do_start;
    logic              w_xfer;
    logic              w_last;
    logic [ADDR_W:0]   w_prog_len;
    logic              w_len_stop;

    assign w_in_run = (r_state == S_RUN);

    // Host requests only act outside RUN; priority clear > load_en > start.
    assign w_do_clear = !w_in_run && clear;
    assign w_do_load  = !w_in_run && !clear && load_en;
    assign w_do_start = !w_in_run && !clear && !load_en && start;

    assign w_xfer = w_in_run && instr_ready;
    assign w_last = ({1'b0, r_idx} == (r_num_inst - c_CNT_ONE));

    // Program length is the run of valid entries starting at index 0; the
    // first hole ends the program even if later entries are valid.
    always_comb begin
        w_prog_len = '0;
        w_len_stop = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!w_len_stop) begin
                if (r_vld[i]) begin
                    w_prog_len = w_prog_len + c_CNT_ONE;
                end else begin
                    w_len_stop = 1'b1;
                end
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_do_clear || w_do_load) begin
                    w_state_nxt = S_IDLE;
                end else if (w_do_start) begin
                    // An empty program completes immediately.
                    w_state_nxt = (w_prog_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_xfer && w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_vld      <= '0;
            r_idx      <= '0;
            r_num_inst <= '0;
            r_issued   <= '0;
            r_load_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_load_err <= w_in_run && (load_en || clear);

            if (w_do_clear) begin
                r_vld <= '0;
            end else if (w_do_load) begin
                r_vld[load_addr] <= 1'b1;
            end

            if (w_do_start) begin
                r_num_inst <= w_prog_len;
                r_idx      <= '0;
                r_issued   <= '0;
            end else if (w_xfer) begin
                // On the final transfer idx of a full program wraps to 0,
                // but the FSM has left RUN so the value is never presented.
                r_idx    <= r_idx + c_IDX_ONE;
                r_issued <= r_issued + c_CNT_ONE;
            end
        end
    end

    // Instruction store: contents survive reset, only valid bits are cleared.
    always_ff @(posedge clk) begin
        if (!reset && w_do_load) begin
            r_mem[load_addr] <= load_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign instr_valid = w_in_run;
    assign instruction = w_in_run ? r_mem[r_idx] : '0;
    assign fetch_pc    = w_in_run ? {{(30-ADDR_W){1'b0}}, r_idx, 2'b00} : 32'd0;
    assign num_inst    = r_num_inst;
    assign issued_cnt  = r_issued;
    assign busy        = w_in_run;
    assign done        = (r_state == S_DONE);
    assign load_err    = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_feeder
//  Description : Directed self-checking bench for instr_feeder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_feeder;

    logic        clk;
    logic        reset;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [31:0] load_data;
    logic        clear;
    logic        start;
    logic        instr_ready;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] fetch_pc;
    logic [4:0]  num_inst;
    logic [4:0]  issued_cnt;
    logic        busy;
    logic        done;
    logic        load_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] prog [4];
    logic        rdy_pat [7];

    instr_feeder #(.DEPTH(16), .ADDR_W(4), .XLEN(32)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .clear       (clear),
        .start       (start),
        .instr_ready (instr_ready),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .fetch_pc    (fetch_pc),
        .num_inst    (num_inst),
        .issued_cnt  (issued_cnt),
        .busy        (busy),
        .done        (done),
        .load_err    (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load_prog4();
        for (int k = 0; k < 4; k++) load(4'(k), prog[k]);
    endtask

    initial begin
        prog[0] = 32'h00500093;
        prog[1] = 32'h00300113;
        prog[2] = 32'h002081B3;
        prog[3] = 32'h00000013;
        rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b0; rdy_pat[2] = 1'b0; rdy_pat[3] = 1'b1;
        rdy_pat[4] = 1'b1; rdy_pat[5] = 1'b0; rdy_pat[6] = 1'b1;

        reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        clear = 1'b0; start = 1'b0; instr_ready = 1'b0;
        tick(); tick();

        // ---------------- reset state ----------------
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instruction, 32'd0);
        check("rst_pc", fetch_pc, 32'd0);
        check("rst_num", 32'(num_inst), 32'd0);
        check("rst_issued", 32'(issued_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_lerr", 32'(load_err), 32'd0);
        reset = 1'b0;
        tick();

        // ---------------- back-to-back issue ----------------
        load_prog4();
        instr_ready = 1'b1;
        do_start();
        check("b2b_num", 32'(num_inst), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("b2b_valid%0d", k), 32'(instr_valid), 32'd1);
            check($sformatf("b2b_instr%0d", k), instruction, prog[k]);
            check($sformatf("b2b_pc%0d", k), fetch_pc, 32'(4 * k));
            tick();
        end
        check("b2b_done", 32'(done), 32'd1);
        check("b2b_issued", 32'(issued_cnt), 32'd4);
        check("b2b_valid_off", 32'(instr_valid), 32'd0);
        check("b2b_instr_off", instruction, 32'd0);

        // ---------------- stalled handshake (rerun from DONE) ----------------
        instr_ready = 1'b0;
        do_start();
        begin
            int exp_k;
            exp_k = 0;
            for (int i = 0; i < 7; i++) begin
                instr_ready = rdy_pat[i];
                check($sformatf("stall_valid%0d", i), 32'(instr_valid), 32'd1);
                check($sformatf("stall_instr%0d", i), instruction, prog[exp_k]);
                check($sformatf("stall_pc%0d", i), fetch_pc, 32'(4 * exp_k));
                tick();
                if (rdy_pat[i]) exp_k++;
            end
        end
        instr_ready = 1'b0;
        check("stall_done", 32'(done), 32'd1);
        check("stall_issued", 32'(issued_cnt), 32'd4);

        // ---------------- gap at entry 2 ----------------
        do_clear();
        load(4'd0, prog[0]);
        load(4'd1, prog[1]);
        load(4'd3, prog[3]);
        instr_ready = 1'b1;
        do_start();
        check("gap_num", 32'(num_inst), 32'd2);
        check("gap_instr0", instruction, prog[0]);
        tick();
        check("gap_instr1", instruction, prog[1]);
        tick();
        check("gap_done", 32'(done), 32'd1);
        check("gap_issued", 32'(issued_cnt), 32'd2);

        // ---------------- empty program ----------------
        do_clear();
        check("clr_done_drop", 32'(done), 32'd0);
        do_start();
        check("empty_done", 32'(done), 32'd1);
        check("empty_valid", 32'(instr_valid), 32'd0);
        check("empty_num", 32'(num_inst), 32'd0);
        check("empty_busy", 32'(busy), 32'd0);

        // ---------------- load attempt during RUN ----------------
        load_prog4();
        instr_ready = 1'b0;
        do_start();
        load_en = 1'b1; load_addr = 4'd0; load_data = 32'hDEADBEEF;
        tick();
        load_en = 1'b0;
        check("lerr_pulse", 32'(load_err), 32'd1);
        check("lerr_hold", instruction, prog[0]);
        tick();
        check("lerr_clear", 32'(load_err), 32'd0);
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("lerr_instr%0d", k), instruction, prog[k]);
            tick();
        end
        check("lerr_done", 32'(done), 32'd1);
        check("lerr_issued", 32'(issued_cnt), 32'd4);

        // ---------------- full 16-word program ----------------
        for (int k = 0; k < 16; k++) load(4'(k), 32'h1000 + 32'(k));
        do_start();
        check("full_num", 32'(num_inst), 32'd16);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("full_instr%0d", k), instruction, 32'h1000 + 32'(k));
            check($sformatf("full_pc%0d", k), fetch_pc, 32'(4 * k));
            tick();
        end
        check("full_done", 32'(done), 32'd1);
        check("full_issued", 32'(issued_cnt), 32'd16);

        // ---------------- reset mid-run ----------------
        do_start();
        for (int k = 0; k < 5; k++) tick();
        check("mid_pc5", fetch_pc, 32'd20);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        instr_ready = 1'b0;
        check("mid_valid", 32'(instr_valid), 32'd0);
        check("mid_instr", instruction, 32'd0);
        check("mid_pc", fetch_pc, 32'd0);
        check("mid_num", 32'(num_inst), 32'd0);
        check("mid_issued", 32'(issued_cnt), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        do_start();
        check("post_done", 32'(done), 32'd1);
        check("post_num", 32'(num_inst), 32'd0);
        check("post_valid", 32'(instr_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_feeder.md
Name: instr_feeder

Overview:
- Program-side counterpart of the RISC-V `datapath`: it stores a small program and drives `instruction` words into the core, replacing the bench-only `$readmemb` plus for-loop stimulus with synthesizable logic.
- A host writes the program into an internal 16-word store through a load port. On `start`, the block issues the words in order over a valid/ready handshake until the loaded program is exhausted, then flags done.
- Sits between a loader (UART/bench) and the datapath's `instruction` input.

Parameters:
- DEPTH, 16, number of instruction words stored.
- ADDR_W, 4, index width; must satisfy 2**ADDR_W == DEPTH.
- XLEN, 32, instruction word width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of `clk`.
- load_en  input  1  write `load_data` into entry `load_addr` this cycle.
- load_addr  input  ADDR_W  entry index for the load.
- load_data  input  XLEN  instruction word to store.
- clear  input  1  invalidate all entries (program length becomes 0).
- start  input  1  begin issuing from entry 0.
- instr_ready  input  1  datapath accepts `instruction` this cycle.
- instruction  output  XLEN  current word; 0 when `instr_valid` = 0.
- instr_valid  output  1  `instruction` is meaningful.
- fetch_pc  output  32  byte address of the current word, equal to idx*4.
- num_inst  output  ADDR_W+1  program length latched at start.
- issued_cnt  output  ADDR_W+1  count of handshakes completed in the current run.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- load_err  output  1  one-cycle pulse when `load_en` or `clear` is attempted during RUN.

Behaviour:
- Storage: `mem[DEPTH]` words plus one valid bit per entry.
- Program length = number of consecutive valid entries starting at index 0; the first invalid entry terminates the program, matching the stop-at-x convention.
- Reset: FSM goes to IDLE; all valid bits are cleared; idx, num_inst and issued_cnt are 0; every output is 0. `mem` contents are not reset.
- FSM states are IDLE, RUN and DONE.
- Behaviour in IDLE or DONE:
  - If `clear` is high, all valid bits are cleared and the FSM goes to IDLE.
  - Else if `load_en` is high, mem[load_addr] is written and its valid bit set; the FSM goes to IDLE and `done` drops.
  - Else if `start` is high: num_inst is latched to the current program length, idx and issued_cnt are set to 0, and the FSM goes to RUN. If the length is 0, the FSM goes straight to DONE instead, and `instr_valid` never rises.
  - Priority order is clear > load_en > start. A lower-priority request in the same cycle is dropped silently, with no `load_err`.
- RUN outputs:
  - `instr_valid` = 1.
  - `instruction` = mem[idx], a combinational read.
  - `fetch_pc` = {idx, 2'b00} zero-extended to 32 bits.
  - The first valid word appears in the cycle after `start` is sampled.
- RUN handshake:
  - A transfer occurs when `instr_valid` && `instr_ready`.
  - On a transfer, idx and issued_cnt each increment by 1.
  - If idx == num_inst-1 at the transfer, the FSM goes to DONE the next cycle.
  - While `instr_ready` = 0, `instruction` and `fetch_pc` hold stable.
- RUN ignores `start`. `load_en` or `clear` in RUN are ignored and raise `load_err` for exactly one cycle.
- DONE outputs: `done` = 1, `instr_valid` = 0, `instruction` = 0. `issued_cnt` holds the final count, which equals num_inst. `start` in DONE re-runs the program from entry 0.
- Wrap-around: a full program of DEPTH words issues entries 0..15. idx never wraps within a run, because the FSM leaves RUN on the last transfer.
- Back-to-back: with `instr_ready` held at 1, exactly one word transfers per cycle. An N-word program spends N cycles in RUN.
- Reset mid-run: the run is abandoned the next edge and all state goes to reset values. The program must be reloaded, since the valid bits are cleared.

Test Plan:
- Load 4 words (0x00500093, 0x00300113, 0x002081B3, 0x00000013) at addrs 0..3, start, hold `instr_ready` = 1 -> `instr_valid` for 4 consecutive cycles; words in order with `fetch_pc` = 0,4,8,12; then `done` = 1 and `issued_cnt` = 4.
- Same program with `instr_ready` toggling 1,0,0,1,1,0,1 -> each word is held stable while ready = 0; exactly 4 transfers; `done` after the 4th.
- Load addrs 0,1,3 (gap at 2), start -> `num_inst` = 2; only words 0 and 1 are issued.
- Start with an empty program -> DONE the next cycle; `instr_valid` never rises; `num_inst` = 0.
- Assert `load_en` during RUN -> `load_err` pulses 1 cycle; the stored word is unchanged and the issue sequence is unaffected.
- Full 16-word load then start -> `fetch_pc` reaches 60 and `issued_cnt` = 16. Assert `reset` at word 5 of a rerun -> all outputs 0 the next cycle, and a subsequent start goes straight to DONE with `num_inst` = 0.
